// File: rtl/noc_rx_depacketizer_pkg.sv
// Shared definitions for the NoC receive depacketizer: header field layout
// and receive FSM state encodings.
package noc_rx_depacketizer_pkg;

  localparam int unsigned NOC_DATA_W = 32;

  // Header flit field offsets
  localparam int unsigned SRC_X_LSB = 0;
  localparam int unsigned SRC_Y_LSB = 4;
  localparam int unsigned LEN_LSB   = 8;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned COORD_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } rx_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk/rst_n (async active-low), push_i/data_i write side,
// pop_i read side, data_o head entry, full_o/empty_o status,
// free_cnt_o number of unused entries.
module noc_sync_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] free_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign free_cnt_o = CNT_W'(DEPTH) - cnt_q;
  assign data_o     = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/noc_rx_depacketizer.sv
// NoC receive depacketizer: decodes header flits, checks body length,
// buffers body flits tagged with source coordinates and streams them out.
// Ports: rx_* flit input from the bridge (rx_ready/rx_VCready flow control),
// pkt_* body-word stream to the core, err_pulse one-cycle protocol error.
module noc_rx_depacketizer
  import noc_rx_depacketizer_pkg::*;
#(
  parameter int unsigned DATA_W     = NOC_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              noc_clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_flit,
  output logic              rx_VCready,
  input  logic              rx_is_header,
  input  logic              rx_is_tail,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_last,
  output logic [3:0]        pkt_src_x,
  output logic [3:0]        pkt_src_y,
  output logic              err_pulse
);

  localparam int unsigned ENTRY_W = DATA_W + 1 + 2 * COORD_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FW      = CNT_W + 1;
  localparam int unsigned LW1     = LEN_W + 1;

  rx_state_e          state_q;
  logic [COORD_W-1:0] src_x_q;
  logic [COORD_W-1:0] src_y_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   body_cnt_q;
  logic               err_q;
  logic               vcready_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   free_cnt;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] push_entry;
  logic               accept_c;
  logic               push_c;
  logic               pop_c;
  logic [FW-1:0]      free_next;
  logic               vcready_d;
  logic [LEN_W-1:0]   hdr_len;

  assign rx_ready   = !fifo_full;
  assign accept_c   = rx_valid && rx_ready;
  assign pop_c      = !fifo_empty && pkt_ready;
  assign push_c     = accept_c && (state_q == BODY) && !rx_is_header;
  assign push_entry = {rx_is_tail, src_y_q, src_x_q, rx_flit};
  assign hdr_len    = rx_flit[LEN_LSB +: LEN_W];

  // Credit hint looks at occupancy after this cycle's push/pop.
  assign free_next = FW'(free_cnt) + FW'(pop_c) - FW'(push_c);
  assign vcready_d = (free_next >= FW'(2));

  noc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (noc_clk),
    .rst_n      (rst_n),
    .push_i     (push_c),
    .data_i     (push_entry),
    .pop_i      (pop_c),
    .data_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .free_cnt_o (free_cnt)
  );

  assign pkt_valid  = !fifo_empty;
  assign pkt_data   = head[DATA_W-1:0];
  assign pkt_src_x  = head[DATA_W +: COORD_W];
  assign pkt_src_y  = head[DATA_W + COORD_W +: COORD_W];
  assign pkt_last   = head[ENTRY_W-1];
  assign err_pulse  = err_q;
  assign rx_VCready = vcready_q;

  // Packet framing FSM; a header+tail flit is treated as a header.
  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_x_q    <= '0;
      src_y_q    <= '0;
      len_q      <= '0;
      body_cnt_q <= '0;
      err_q      <= 1'b0;
      vcready_q  <= 1'b0;
    end else begin
      err_q     <= 1'b0;
      vcready_q <= vcready_d;
      if (accept_c) begin
        case (state_q)
          IDLE: begin
            if (rx_is_header) begin
              if (rx_is_tail) begin
                if (hdr_len != '0) err_q <= 1'b1;
              end else begin
                src_x_q    <= rx_flit[SRC_X_LSB +: COORD_W];
                src_y_q    <= rx_flit[SRC_Y_LSB +: COORD_W];
                len_q      <= hdr_len;
                body_cnt_q <= '0;
                state_q    <= BODY;
              end
            end else begin
              err_q <= 1'b1;
              if (!rx_is_tail) state_q <= DROP;
            end
          end
          BODY: begin
            if (rx_is_header) begin
              err_q   <= 1'b1;
              state_q <= DROP;
            end else begin
              if (body_cnt_q != '1) body_cnt_q <= body_cnt_q + LEN_W'(1);
              if (rx_is_tail) begin
                if ((LW1'(body_cnt_q) + LW1'(1)) != LW1'(len_q)) err_q <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          DROP: begin
            if (rx_is_tail) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_noc_rx_depacketizer.sv
// Self-checking bench for noc_rx_depacketizer: directed packet scenarios
// followed by randomized packet traffic, checked every cycle against a
// packet-level queue model.
module tb_noc_rx_depacketizer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  localparam int OUTSIDE  = 0;
  localparam int INSIDE   = 1;
  localparam int SKIPPING = 2;

  logic          noc_clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic          rx_ready;
  logic [DW-1:0] rx_flit;
  logic          rx_VCready;
  logic          rx_is_header;
  logic          rx_is_tail;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [DW-1:0] pkt_data;
  logic          pkt_last;
  logic [3:0]    pkt_src_x;
  logic [3:0]    pkt_src_y;
  logic          err_pulse;

  noc_rx_depacketizer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .noc_clk      (noc_clk),
    .rst_n        (rst_n),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_flit      (rx_flit),
    .rx_VCready   (rx_VCready),
    .rx_is_header (rx_is_header),
    .rx_is_tail   (rx_is_tail),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_data     (pkt_data),
    .pkt_last     (pkt_last),
    .pkt_src_x    (pkt_src_x),
    .pkt_src_y    (pkt_src_y),
    .err_pulse    (err_pulse)
  );

  always #5 noc_clk = ~noc_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [3:0]    x;
    logic [3:0]    y;
  } word_t;

  // Reference model: expected delivered words plus packet-level context.
  word_t      mq[$];
  int         mode;
  logic [3:0] cur_x, cur_y;
  int         cur_len, got;
  logic       exp_err, exp_vc;
  logic       last_acc;

  int checks, passes;
  int errs_seen, delivered;
  int prp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] hdr(input int x, input int y, input int len);
    logic [15:0] rsv;
    rsv = 16'($urandom);
    return {rsv, 8'(len), 4'(y), 4'(x)};
  endfunction

  task automatic model_reset();
    mq.delete();
    mode    = OUTSIDE;
    exp_err = 1'b0;
    exp_vc  = 1'b0;
    got     = 0;
  endtask

  task automatic check_outputs();
    chk("rx_ready", 64'(rx_ready), 64'(mq.size() < DEPTH));
    chk("pkt_valid", 64'(pkt_valid), 64'(mq.size() != 0));
    chk("err_pulse", 64'(err_pulse), 64'(exp_err));
    chk("rx_VCready", 64'(rx_VCready), 64'(exp_vc));
    if (mq.size() != 0) begin
      chk("pkt_data", 64'(pkt_data), 64'(mq[0].data));
      chk("pkt_last", 64'(pkt_last), 64'(mq[0].last));
      chk("pkt_src", 64'({pkt_src_y, pkt_src_x}), 64'({mq[0].y, mq[0].x}));
    end
    if (err_pulse === 1'b1) errs_seen++;
    if (pkt_valid === 1'b1 && pkt_ready) delivered++;
  endtask

  // Advance the packet-level model by one clock using current inputs.
  task automatic model_step();
    logic  acc, pop, err;
    word_t w;
    acc = rx_valid && (mq.size() < DEPTH);
    pop = (mq.size() != 0) && pkt_ready;
    err = 1'b0;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      if (rx_is_header) begin
        if (mode == INSIDE) begin
          err  = 1'b1;
          mode = SKIPPING;
        end else if (mode == SKIPPING) begin
          if (rx_is_tail) mode = OUTSIDE;
        end else if (rx_is_tail) begin
          err = (rx_flit[15:8] != 8'd0);
        end else begin
          cur_x   = rx_flit[3:0];
          cur_y   = rx_flit[7:4];
          cur_len = int'(rx_flit[15:8]);
          got     = 0;
          mode    = INSIDE;
        end
      end else begin
        if (mode == OUTSIDE) begin
          err = 1'b1;
          if (!rx_is_tail) mode = SKIPPING;
        end else if (mode == INSIDE) begin
          w.data = rx_flit; w.last = rx_is_tail; w.x = cur_x; w.y = cur_y;
          mq.push_back(w);
          got++;
          if (rx_is_tail) begin
            err  = (got != cur_len);
            mode = OUTSIDE;
          end
        end else if (rx_is_tail) begin
          mode = OUTSIDE;
        end
      end
    end
    last_acc = acc;
    exp_err  = err;
    exp_vc   = (int'(DEPTH) - mq.size()) >= 2;
  endtask

  task automatic cycle(input logic v, input logic h, input logic t,
                       input logic [DW-1:0] f, input logic pr);
    rx_valid = v; rx_is_header = h; rx_is_tail = t; rx_flit = f; pkt_ready = pr;
    @(negedge noc_clk);
    check_outputs();
    model_step();
    @(posedge noc_clk);
    #1;
  endtask

  function automatic logic pick_pr(input int m);
    if (m == 2) return ($urandom_range(0, 99) < prp);
    return m[0];
  endfunction

  // Hold a flit on the bus until the model says it was accepted.
  task automatic send(input logic h, input logic t, input logic [DW-1:0] f, input int prm);
    for (int n = 0; n < 200; n++) begin
      cycle(1'b1, h, t, f, pick_pr(prm));
      if (last_acc) return;
    end
    chk("send_timeout", 64'(last_acc), 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'(0), 1'b1);
      if (mq.size() == 0 && !exp_err) return;
    end
    chk("drain_timeout", 64'(mq.size()), 64'd0);
  endtask

  initial begin
    int e0, d0, nb, len, k;
    checks = 0; passes = 0; errs_seen = 0; delivered = 0; prp = 75;
    rst_n = 1'b0; rx_valid = 1'b0; rx_is_header = 1'b0; rx_is_tail = 1'b0;
    rx_flit = '0; pkt_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge noc_clk);
    #1;
    chk("rst_rx_ready", 64'(rx_ready), 64'd1);
    chk("rst_vcready", 64'(rx_VCready), 64'd0);
    chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("rst_pkt_data", 64'(pkt_data), 64'd0);
    chk("rst_pkt_last", 64'(pkt_last), 64'd0);
    chk("rst_src", 64'({pkt_src_y, pkt_src_x}), 64'd0);
    chk("rst_err", 64'(err_pulse), 64'd0);
    rst_n = 1'b1;

    // Nominal packet
    e0 = errs_seen; d0 = delivered;
    send(1'b1, 1'b0, hdr(2, 1, 3), 1);
    send(1'b0, 1'b0, 32'hAAAA_0001, 1);
    send(1'b0, 1'b0, 32'hBBBB_0002, 1);
    send(1'b0, 1'b1, 32'hCCCC_0003, 1);
    drain();
    chk("nominal_err", 64'(errs_seen - e0), 64'd0);
    chk("nominal_words", 64'(delivered - d0), 64'd3);

    // Backpressure: FIFO fills, no loss
    e0 = errs_seen; d0 = delivered;
    send(1'b1, 1'b0, hdr(5, 6, 5), 0);
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 32'h5000_0000 + 32'(i), 0);
    cycle(1'b0, 1'b0, 1'b0, 32'(0), 1'b0);
    chk("bp_rx_ready_low", 64'(rx_ready), 64'd0);
    chk("bp_vcready_low", 64'(rx_VCready), 64'd0);
    send(1'b0, 1'b1, 32'h5000_0004, 1);
    drain();
    chk("bp_err", 64'(errs_seen - e0), 64'd0);
    chk("bp_words", 64'(delivered - d0), 64'd5);

    // Length mismatch
    e0 = errs_seen; d0 = delivered;
    send(1'b1, 1'b0, hdr(7, 2, 4), 1);
    send(1'b0, 1'b0, 32'h1111_0001, 1);
    send(1'b0, 1'b1, 32'h1111_0002, 1);
    drain();
    chk("mismatch_err", 64'(errs_seen - e0), 64'd1);
    chk("mismatch_words", 64'(delivered - d0), 64'd2);

    // Orphan body flits then a good packet
    e0 = errs_seen; d0 = delivered;
    send(1'b0, 1'b0, 32'hDEAD_0001, 1);
    send(1'b0, 1'b0, 32'hDEAD_0002, 1);
    send(1'b0, 1'b1, 32'hDEAD_0003, 1);
    send(1'b1, 1'b0, hdr(4, 4, 1), 1);
    send(1'b0, 1'b1, 32'h600D_0001, 1);
    drain();
    chk("orphan_err", 64'(errs_seen - e0), 64'd1);
    chk("orphan_words", 64'(delivered - d0), 64'd1);

    // Back-to-back packets while the first is still buffered
    e0 = errs_seen; d0 = delivered;
    send(1'b1, 1'b0, hdr(1, 0, 2), 0);
    send(1'b0, 1'b0, 32'hB1B1_0001, 0);
    send(1'b0, 1'b1, 32'hB1B1_0002, 0);
    send(1'b1, 1'b0, hdr(3, 3, 2), 0);
    send(1'b0, 1'b0, 32'hB2B2_0001, 0);
    send(1'b0, 1'b1, 32'hB2B2_0002, 0);
    drain();
    chk("b2b_err", 64'(errs_seen - e0), 64'd0);
    chk("b2b_words", 64'(delivered - d0), 64'd4);

    // Zero-length packets: legal and illegal length field
    e0 = errs_seen;
    send(1'b1, 1'b1, hdr(9, 9, 0), 1);
    send(1'b1, 1'b1, hdr(9, 9, 3), 1);
    drain();
    chk("zero_len_err", 64'(errs_seen - e0), 64'd1);

    // Randomized packet traffic
    for (int p = 0; p < 150; p++) begin
      prp = $urandom_range(10, 100);
      k = $urandom_range(0, 9);
      if (k == 0) begin
        nb = $urandom_range(1, 2);
        for (int i = 0; i < nb; i++)
          send(1'b0, (i == nb - 1) && ($urandom_range(0, 1) == 1), $urandom, 2);
      end else if (k == 1) begin
        send(1'b1, 1'b1, hdr($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1)), 2);
      end else if (k == 2) begin
        send(1'b1, 1'b0, hdr($urandom_range(0, 15), $urandom_range(0, 15), 3), 2);
        nb = $urandom_range(0, 2);
        for (int i = 0; i < nb; i++) send(1'b0, 1'b0, $urandom, 2);
      end else begin
        len = $urandom_range(1, 6);
        nb  = len;
        if ($urandom_range(0, 4) == 0) nb = ($urandom_range(0, 1) == 1) ? len + 1 : len - 1;
        if (nb < 1) nb = 1;
        send(1'b1, 1'b0, hdr($urandom_range(0, 15), $urandom_range(0, 15), len), 2);
        for (int i = 0; i < nb; i++) begin
          if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 1'b0, $urandom, pick_pr(2));
          send(1'b0, i == nb - 1, $urandom, 2);
        end
      end
    end
    drain();

    // Mid-packet asynchronous reset, then a fresh packet
    send(1'b1, 1'b0, hdr(6, 5, 5), 0);
    send(1'b0, 1'b0, 32'h7777_0001, 0);
    send(1'b0, 1'b0, 32'h7777_0002, 0);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("mid_rst_pkt_data", 64'(pkt_data), 64'd0);
    chk("mid_rst_pkt_last", 64'(pkt_last), 64'd0);
    chk("mid_rst_src", 64'({pkt_src_y, pkt_src_x}), 64'd0);
    chk("mid_rst_err", 64'(err_pulse), 64'd0);
    chk("mid_rst_rx_ready", 64'(rx_ready), 64'd1);
    chk("mid_rst_vcready", 64'(rx_VCready), 64'd0);
    model_reset();
    @(posedge noc_clk);
    #1 rst_n = 1'b1;
    e0 = errs_seen; d0 = delivered;
    send(1'b1, 1'b0, hdr(8, 2, 1), 1);
    send(1'b0, 1'b1, 32'hF00D_0001, 1);
    drain();
    chk("post_rst_err", 64'(errs_seen - e0), 64'd0);
    chk("post_rst_words", 64'(delivered - d0), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/noc_rx_depacketizer.md
Name: noc_rx_depacketizer

Overview:
- Receive-side stage directly downstream of the NoC bridge's router-facing receive port (valid/ready, flit, VCready, is_header, is_tail).
- Strips and decodes header flits and checks body length against the header.
- Buffers body flits in a small FIFO and presents them to the local core as a packet stream tagged with source coordinates.
- Malformed packets are dropped or flagged.

Parameters:
- DATA_W, 32, flit width; equals `Noc_Data_Width.
- FIFO_DEPTH, 4, body-flit buffer entries; power of two, minimum 2.

Ports:
- noc_clk  in  1  clock.
- rst_n  in  1  reset.
- rx_valid  in  1  flit valid from bridge receive port.
- rx_ready  out  1  stage can accept a flit this cycle.
- rx_flit  in  DATA_W  flit data.
- rx_VCready  out  1  VC has at least 2 free slots (credit hint to router).
- rx_is_header  in  1  flit is a header.
- rx_is_tail  in  1  flit is a tail.
- pkt_valid  out  1  body word available.
- pkt_ready  in  1  consumer accepts word.
- pkt_data  out  DATA_W  body word.
- pkt_last  out  1  word is the packet's final body word.
- pkt_src_x  out  4  source X of the packet owning pkt_data.
- pkt_src_y  out  4  source Y of the packet owning pkt_data.
- err_pulse  out  1  one-cycle protocol-error strobe.

Behaviour:
- Clock and reset: single clock noc_clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - rx_ready=1.
  - rx_VCready=0; it rises the first cycle after reset deasserts.
  - pkt_valid=0, pkt_last=0, pkt_data=0, pkt_src_x=0, pkt_src_y=0.
  - err_pulse=0.
  - FSM=IDLE, FIFO empty, counters 0.
- Header flit format:
  - [3:0] src_x, [7:4] src_y.
  - [15:8] len = number of body flits (tail included in the count).
  - [DATA_W-1:16] reserved, ignored.
- Input accept: a flit is accepted when rx_valid && rx_ready. rx_ready = !fifo_full, combinational from the registered count.
- rx_VCready: registered; next value = (free entries after this cycle's push/pop) >= 2.
- FSM IDLE:
  - Accepted header with no tail: latch src_x, src_y, len; clear body_cnt; go to BODY. The header is never pushed to the FIFO.
  - Accepted header with tail: zero-length packet, nothing pushed. If len!=0, assert err_pulse. Stay in IDLE.
  - Accepted non-header flit: assert err_pulse. If is_tail, stay in IDLE; otherwise go to DROP. The flit is discarded.
- FSM BODY:
  - Accepted non-header flit: push {is_tail, src_y, src_x, flit}; body_cnt increments, saturating at 255.
  - On a tail flit: if body_cnt+1 != len, assert err_pulse. The tail is still delivered with pkt_last=1. Go to IDLE.
  - Accepted header (missing tail): assert err_pulse; discard the header; go to DROP. The flits already in the FIFO keep their data, but the last pushed flit is not retro-marked last.
- FSM DROP:
  - Accept and discard every flit; rx_ready is still governed by FIFO full.
  - On an accepted tail, go to IDLE. No further err_pulse is raised while in DROP.
- FIFO and output:
  - First-word fall-through; entry width DATA_W+9.
  - pkt_valid = !empty; pkt_data, pkt_last, pkt_src_x, pkt_src_y are taken from the head entry.
  - A pop occurs when pkt_valid && pkt_ready.
- Boundary conditions:
  - Simultaneous push and pop leaves the count unchanged.
  - When full, rx_ready=0 even if a pop occurs that cycle (no same-cycle bypass).
  - Pointers wrap modulo FIFO_DEPTH.
  - Latency from an accepted body flit to pkt_valid: 1 cycle.
- Other rules:
  - Source coordinates travel with each entry, so a new header may arrive while the previous packet is still draining.
  - rx_is_header and rx_is_tail both set on a flit counts as a header.
  - Reset asserted mid-packet empties the FIFO, returns to IDLE and clears err_pulse immediately.

Decomposition:
- Shared include (alongside the NoC parameter file):
  - header field offsets (SRC_X_LSB=0, SRC_Y_LSB=4, LEN_LSB=8, LEN_W=8);
  - FSM state encodings IDLE=2'd0, BODY=2'd1, DROP=2'd2.
- One sub-module, noc_sync_fifo (parameters WIDTH, DEPTH):
  - ports: push, pop, full, empty, free_cnt, head data;
  - asynchronous active-low reset.

Test Plan:
- Nominal packet: header(len=3, x=2, y=1), body A, B, C(tail) with pkt_ready=1 -> three pkt_valid beats A, B, C with src (2,1); pkt_last only on C; err_pulse never asserts.
- Backpressure: 6-flit packet (len=5), pkt_ready=0 -> rx_ready drops after 4 body flits; rx_VCready falls once free slots <2. Then pkt_ready=1 -> all 5 delivered in order, no loss.
- Length mismatch: header(len=4) followed by 2 body flits, the second a tail -> one err_pulse on tail accept; 2 words delivered, second with pkt_last=1.
- Orphan body: body flit (no tail) in IDLE, then 2 more ending in tail, then a valid header(len=1) + tail -> exactly one err_pulse; only the last packet's word appears.
- Back-to-back packets: packet P1 from src (1,0), then immediately P2 from src (3,3) while P1 is still buffered with pkt_ready=0 -> P1 words tagged (1,0) and P2 words tagged (3,3).
- Mid-packet reset: assert rst_n=0 after 2 body flits of a len=5 packet -> outputs return to reset values asynchronously. A fresh packet after release is delivered correctly.
